// File: rtl/priority_encoder_16to4.sv
// Sticky 16-bit request collector with a strict MSB-first grant and a valid/ready output.
// Latency: 2 edges from req_in to out_valid; out_code is held frozen until accepted, and one grant is issued per 2 cycles at most.
module priority_encoder_16to4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_code,
    output logic [15:0] pending,
    output logic        dropped
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [3:0]  r_code;
    logic [15:0] r_pending;
    logic        r_dropped;

    logic [15:0] w_clr;
    logic [15:0] w_pending_nxt;
    logic [15:0] w_hit;
    logic [3:0]  w_top;

    always_comb begin
        w_top = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_pending[i]) w_top = 4'(i);
        end
    end

    // The clear is applied before the OR so a request on the handshake edge re-arms its bit.
    assign w_clr         = (r_state == HOLD && out_ready) ? (16'h0001 << r_code) : 16'h0000;
    assign w_pending_nxt = (r_pending & ~w_clr) | req_in;
    assign w_hit         = req_in & r_pending & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_code    <= 4'h0;
            r_pending <= 16'h0000;
            r_dropped <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (|w_hit) r_dropped <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_code  <= w_top;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign pending   = r_pending;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_priority_encoder_16to4.sv
// Directed bench for priority_encoder_16to4; observed tuple is {out_valid, out_code, pending, dropped}.
module tb_priority_encoder_16to4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_code;
    logic [15:0] pending;
    logic        dropped;

    logic [21:0] obs;
    logic [21:0] exp_v;
    int          n_vec;
    int          n_err;

    priority_encoder_16to4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending),
        .dropped   (dropped)
    );

    assign obs = {out_valid, out_code, pending, dropped};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_in    = 16'h0000;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_in    = 16'hFFFF;
        out_ready = 1'b1;
        step();
        step();
        exp_v = {1'b0, 4'h0, 16'h0000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", obs, exp_v);
        end
        rst_n  = 1'b1;
        req_in = 16'h0000;
    endtask

    task automatic test_single();
        do_reset();
        req_in    = 16'h0020;
        out_ready = 1'b1;
        step();
        req_in = 16'h0000;
        exp_v = {1'b0, 4'h0, 16'h0020, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL single_e1 got=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {1'b1, 4'h5, 16'h0020, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL single_grant got=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {1'b0, 4'h5, 16'h0000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL single_done got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_priority();
        logic [3:0]  codes [3];
        logic [15:0] left  [3];
        codes = '{4'hF, 4'h8, 4'h0};
        left  = '{16'h0101, 16'h0001, 16'h0000};
        do_reset();
        req_in    = 16'h8101;
        out_ready = 1'b1;
        step();
        req_in = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_v = {1'b1, codes[k], (k == 0) ? 16'h8101 : left[k-1], 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL prio_grant%0d got=%h exp=%h", k, obs, exp_v);
            end
            step();
            exp_v = {1'b0, codes[k], left[k], 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL prio_ack%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
        step();
        exp_v = {1'b0, 4'h0, 16'h0000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL prio_idle got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_in    = 16'h0004;
        out_ready = 1'b0;
        step();
        req_in = 16'h0000;
        step();
        req_in = 16'h4000;
        step();
        req_in = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            exp_v = {1'b1, 4'h2, 16'h4004, 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL bp_freeze%0d got=%h exp=%h", k, obs, exp_v);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        exp_v = {1'b0, 4'h2, 16'h4000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL bp_ack got=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {1'b1, 4'hE, 16'h4000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL bp_next got=%h exp=%h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_set_wins();
        do_reset();
        req_in    = 16'h0008;
        out_ready = 1'b0;
        step();
        req_in = 16'h0000;
        step();
        req_in    = 16'h0008;
        out_ready = 1'b1;
        step();
        req_in = 16'h0000;
        exp_v = {1'b0, 4'h3, 16'h0008, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL setwin_keep got=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {1'b1, 4'h3, 16'h0008, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL setwin_regrant got=%h exp=%h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_drop();
        do_reset();
        req_in    = 16'h0010;
        out_ready = 1'b0;
        step();
        req_in = 16'h0000;
        step();
        req_in = 16'h0010;
        step();
        req_in = 16'h0000;
        exp_v = {1'b1, 4'h4, 16'h0010, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL drop_set got=%h exp=%h", obs, exp_v);
        end
        out_ready = 1'b1;
        step();
        step();
        step();
        exp_v = {1'b0, 4'h4, 16'h0000, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL drop_sticky got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_in    = 16'h00FF;
        out_ready = 1'b0;
        step();
        req_in = 16'h0000;
        step();
        exp_v = {1'b1, 4'h7, 16'h00FF, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mrst_hold got=%h exp=%h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {1'b0, 4'h0, 16'h0000, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mrst_async got=%h exp=%h", obs, exp_v);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mrst_quiet got=%h exp=%h", obs, exp_v);
        end
        req_in = 16'h0001;
        step();
        req_in = 16'h0000;
        exp_v = {1'b0, 4'h0, 16'h0001, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL mrst_resample got=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_in    = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_set_wins();
        test_drop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/priority_encoder_16to4.md
PRIORITY_ENCODER_16TO4 -- requirements
Module: priority_encoder_16to4

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req_in, input, 16 bits: request strobes; bit i set requests code i.
REQ-004 SHALL have port out_ready, input, 1 bit: consumer accepts out_code when high together with out_valid.
REQ-005 SHALL have port out_valid, output, 1 bit: out_code holds a granted request.
REQ-006 SHALL have port out_code, output, 4 bits: binary index of the granted request.
REQ-007 SHALL have port pending, output, 16 bits: registered pending-request vector.
REQ-008 SHALL have port dropped, output, 1 bit: sticky flag for a request that hit an already-pending bit.

Function
REQ-009 SHALL OR req_in into pending at every rising edge: pending_next = (pending & ~clr) | req_in.
REQ-010 SHALL form the 16-bit vector clr as one-hot(out_code) only at an edge where out_valid && out_ready; otherwise clr = 0.
REQ-011 SHALL let a set win over a clear: if req_in[out_code] is high on the handshake edge, that pending bit stays 1.
REQ-012 SHALL implement a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 In IDLE, if pending != 0 at an edge, the block SHALL load out_code with the highest set index of pending and go to HOLD; otherwise it SHALL stay in IDLE.
REQ-014 In IDLE, the block SHALL evaluate only the registered pending value, so req_in sampled at edge E1 gives out_valid=1 after edge E2 at the earliest (2-cycle latency).
REQ-015 In HOLD, out_code SHALL stay frozen, including when a higher-index request arrives.
REQ-016 In HOLD, on an edge with out_ready=1, the block SHALL clear the granted bit per REQ-010/011 and return to IDLE; with out_ready=0 it SHALL remain in HOLD.
REQ-017 Maximum throughput SHALL be one grant per 2 cycles (mandatory IDLE cycle after each handshake).
REQ-018 SHALL make priority strict MSB-first: index 15 highest, index 0 lowest; no fairness or rotation.
REQ-019 SHALL set dropped to 1 at any edge where (req_in & pending & ~clr) != 0; dropped SHALL then hold 1 until reset.
REQ-020 out_ready while in IDLE SHALL have no effect.
REQ-021 Simultaneous multi-bit req_in SHALL all be captured in pending, then served in descending index order.

Reset
REQ-022 While rst_n=0, the block SHALL hold, independent of clk: FSM=IDLE, pending=16'h0000, out_valid=0, out_code=4'h0, dropped=0.
REQ-023 Reset asserted in HOLD SHALL abort the grant immediately: out_valid falls with no handshake and all pending requests are lost.
REQ-024 After rst_n deasserts, the first edge SHALL sample req_in normally; no extra idle cycles.

Verification
REQ-025 Single request: req_in=16'h0020 for 1 cycle, out_ready=1 -> out_valid=1, out_code=4'h5 two edges later; pending=0 after the handshake edge.
REQ-026 Priority order: req_in=16'h8101 for 1 cycle, out_ready=1 -> codes F, 8, 0 in order, one every 2 cycles; out_valid then 0.
REQ-027 Backpressure and freeze: req_in=16'h0004 for 1 cycle, out_ready=0; in HOLD pulse req_in=16'h4000 -> out_code stays 4'h2 until out_ready=1; next grant is 4'hE.
REQ-028 Set-wins collision: in HOLD with out_code=4'h3, req_in=16'h0008 on the handshake edge -> pending[3] stays 1, dropped stays 0, code 3 granted again after the IDLE cycle.
REQ-029 Drop detect: pending=16'h0010 with out_ready=0, req_in=16'h0010 again -> dropped=1 and remains 1 through later handshakes until reset.
REQ-030 Mid-operation reset: HOLD with pending=16'h00FF, assert rst_n=0 between edges -> out_valid, pending, out_code and dropped go to 0 immediately; no output until a new req_in.
